// File: rtl/aes_reg_master.sv
// aes_reg_master: REG_BUS initiator that runs one AES-192 block job per
// plaintext handshake against the memory-mapped AES register block and
// returns the ciphertext (or an error flag) on a result handshake.
//
// state  | meaning
// IDLE   | waiting for a plaintext job, pt_ready_o high
// CLR    | write 0 to control (index 0) so start is low before loading
// WPT0-3 | write plaintext words to index 1..4, least significant word first
// SET    | write 1 to control (index 0) to launch the core
// POLL   | read status (index 11) until bit 0 is set or the poll budget runs out
// RCT0-3 | read ciphertext from index 12..15, most significant word first
// RESP   | present result/error on ct_o/ct_err_o until ct_ready_i
module aes_reg_master #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           POLL_MAX   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [127:0]          pt_i,
    input  logic                  pt_valid_i,
    output logic                  pt_ready_o,
    output logic [127:0]          ct_o,
    output logic                  ct_err_o,
    output logic                  ct_valid_o,
    input  logic                  ct_ready_i,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic                  bus_write_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_wstrb_o,
    output logic                  bus_valid_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ready_i,
    input  logic                  bus_error_i
);

    // Wide enough to hold POLL_MAX itself, the terminal count.
    localparam int unsigned CW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR,
        S_WPT0, S_WPT1, S_WPT2, S_WPT3,
        S_SET,  S_POLL,
        S_RCT0, S_RCT1, S_RCT2, S_RCT3,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [127:0]          pt_q, pt_d;
    logic [127:0]          ct_q, ct_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         poll_cnt_q, poll_cnt_d;
    logic [CW-1:0]         poll_inc;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_write_q, bus_write_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]            reg_idx;
    logic                  bus_done;

    assign bus_done = bus_valid_q & bus_ready_i;
    assign poll_inc = poll_cnt_q + CW'(1);

    // Sequencer: advance one step per completed bus transaction, abort on error.
    always_comb begin
        state_d    = state_q;
        pt_d       = pt_q;
        ct_d       = ct_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pt_valid_i) begin
                    pt_d       = pt_i;
                    ct_d       = '0;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    state_d    = S_CLR;
                end
            end
            S_RESP: begin
                if (ct_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (bus_done) begin
                    if (bus_error_i) begin
                        // Abandon the job; start may stay set, the next CLR drops it.
                        err_d   = 1'b1;
                        ct_d    = '0;
                        state_d = S_RESP;
                    end else begin
                        case (state_q)
                            S_CLR:  state_d = S_WPT0;
                            S_WPT0: state_d = S_WPT1;
                            S_WPT1: state_d = S_WPT2;
                            S_WPT2: state_d = S_WPT3;
                            S_WPT3: state_d = S_SET;
                            S_SET:  state_d = S_POLL;
                            S_POLL: begin
                                if (bus_rdata_i[0]) begin
                                    state_d = S_RCT0;
                                end else begin
                                    poll_cnt_d = poll_inc;
                                    if (poll_inc == CW'(POLL_MAX)) begin
                                        err_d   = 1'b1;
                                        ct_d    = '0;
                                        state_d = S_RESP;
                                    end
                                end
                            end
                            S_RCT0: begin
                                ct_d[127:96] = bus_rdata_i[31:0];
                                state_d      = S_RCT1;
                            end
                            S_RCT1: begin
                                ct_d[95:64] = bus_rdata_i[31:0];
                                state_d     = S_RCT2;
                            end
                            S_RCT2: begin
                                ct_d[63:32] = bus_rdata_i[31:0];
                                state_d     = S_RCT3;
                            end
                            S_RCT3: begin
                                ct_d[31:0] = bus_rdata_i[31:0];
                                state_d    = S_RESP;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // Bus request for the state being entered, so a new transaction can
    // follow a completion with no idle cycle; unchanged while stalled.
    always_comb begin
        bus_valid_d = 1'b1;
        bus_write_d = 1'b1;
        bus_wdata_d = '0;
        reg_idx     = 4'd0;
        case (state_d)
            S_CLR: begin
                reg_idx     = 4'd0;
                bus_wdata_d = '0;
            end
            S_WPT0: begin
                reg_idx     = 4'd1;
                bus_wdata_d = pt_d[31:0];
            end
            S_WPT1: begin
                reg_idx     = 4'd2;
                bus_wdata_d = pt_d[63:32];
            end
            S_WPT2: begin
                reg_idx     = 4'd3;
                bus_wdata_d = pt_d[95:64];
            end
            S_WPT3: begin
                reg_idx     = 4'd4;
                bus_wdata_d = pt_d[127:96];
            end
            S_SET: begin
                reg_idx     = 4'd0;
                bus_wdata_d = DATA_WIDTH'(1);
            end
            S_POLL: begin
                reg_idx     = 4'd11;
                bus_write_d = 1'b0;
            end
            S_RCT0: begin
                reg_idx     = 4'd12;
                bus_write_d = 1'b0;
            end
            S_RCT1: begin
                reg_idx     = 4'd13;
                bus_write_d = 1'b0;
            end
            S_RCT2: begin
                reg_idx     = 4'd14;
                bus_write_d = 1'b0;
            end
            S_RCT3: begin
                reg_idx     = 4'd15;
                bus_write_d = 1'b0;
            end
            default: begin
                bus_valid_d = 1'b0;
                bus_write_d = 1'b0;
            end
        endcase
        // Idle bus shows all-zero address rather than BASE_ADDR.
        bus_addr_d = bus_valid_d ? (BASE_ADDR + ADDR_WIDTH'({reg_idx, 2'b00})) : '0;
    end

    // State, job data and registered bus request; reset drops the bus at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pt_q        <= '0;
            ct_q        <= '0;
            err_q       <= 1'b0;
            poll_cnt_q  <= '0;
            bus_valid_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            err_q       <= err_d;
            poll_cnt_q  <= poll_cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign pt_ready_o  = (state_q == S_IDLE);
    assign ct_valid_o  = (state_q == S_RESP);
    assign ct_o        = ct_q;
    assign ct_err_o    = err_q;
    assign bus_valid_o = bus_valid_q;
    assign bus_write_o = bus_write_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wstrb_o = {4{bus_write_q}};

endmodule

// File: tb/tb_aes_reg_master.sv
// Directed bench for aes_reg_master with a behavioural REG_BUS target.
module tb_aes_reg_master;

    localparam logic [31:0]  BASE   = 32'h4000_0100;
    localparam int           PMAX   = 4;
    localparam logic [127:0] EXP_CT = 128'h01234567_89abcdef_fedcba98_76543210;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    logic         clk_i       = 1'b0;
    logic         rst_i       = 1'b1;
    logic [127:0] pt_i        = '0;
    logic         pt_valid_i  = 1'b0;
    logic         pt_ready_o;
    logic [127:0] ct_o;
    logic         ct_err_o;
    logic         ct_valid_o;
    logic         ct_ready_i  = 1'b1;
    logic [31:0]  bus_addr_o;
    logic         bus_write_o;
    logic [31:0]  bus_wdata_o;
    logic [3:0]   bus_wstrb_o;
    logic         bus_valid_o;
    logic [31:0]  bus_rdata_i = '0;
    logic         bus_ready_i = 1'b0;
    logic         bus_error_i = 1'b0;

    int total = 0;
    int bad   = 0;

    aes_reg_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BASE_ADDR (BASE),
        .POLL_MAX  (PMAX)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pt_i       (pt_i),
        .pt_valid_i (pt_valid_i),
        .pt_ready_o (pt_ready_o),
        .ct_o       (ct_o),
        .ct_err_o   (ct_err_o),
        .ct_valid_o (ct_valid_o),
        .ct_ready_i (ct_ready_i),
        .bus_addr_o (bus_addr_o),
        .bus_write_o(bus_write_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_wstrb_o(bus_wstrb_o),
        .bus_valid_o(bus_valid_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ready_i(bus_ready_i),
        .bus_error_i(bus_error_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rd_word(input int k);
        logic [127:0] w;
        w = EXP_CT;
        return w[127-32*k -: 32];
    endfunction

    // Target-side controls (written by tests) and records (written by the target).
    int   poll_ok_at = 0;
    int   poll_base  = 0;
    int   stall_req  = 0;
    bit   err_on_set = 1'b0;
    int   log_base   = 0;
    int   stall_base = 0;
    int   polls_done = 0;
    int   stall_done = 0;
    txn_t        log_q[$];
    logic [31:0] stall_addr_q[$];
    logic [31:0] stall_wdata_q[$];

    // Target responds on the falling edge so the DUT samples settled inputs.
    always @(negedge clk_i) begin
        int   idx;
        bit   stalled;
        txn_t t;
        idx     = int'((bus_addr_o - BASE) >> 2);
        stalled = bus_valid_o && bus_write_o && idx == 3 && stall_done < stall_req;
        if (stalled) begin
            stall_done++;
            stall_addr_q.push_back(bus_addr_o);
            stall_wdata_q.push_back(bus_wdata_o);
        end
        bus_ready_i = !stalled;
        bus_error_i = err_on_set && bus_valid_o && bus_write_o && idx == 0 && bus_wdata_o == 32'd1;
        bus_rdata_i = 32'h5A5A_5A5A;
        if (bus_valid_o && !bus_write_o) begin
            if (idx == 11)
                bus_rdata_i = (poll_ok_at != 0 && polls_done - poll_base + 1 >= poll_ok_at)
                              ? 32'h8000_0001 : 32'hFFFF_FFFE;
            else if (idx >= 12 && idx <= 15)
                bus_rdata_i = rd_word(idx - 12);
        end
        if (bus_valid_o && bus_ready_i) begin
            t.w    = bus_write_o;
            t.addr = bus_addr_o;
            t.data = bus_write_o ? bus_wdata_o : bus_rdata_i;
            t.strb = bus_wstrb_o;
            log_q.push_back(t);
            if (!bus_write_o && idx == 11) polls_done++;
        end
    end

    txn_t exp_q[$];

    function automatic txn_t mk(input logic w, input int idx, input logic [31:0] d);
        txn_t t;
        t.w    = w;
        t.addr = BASE + 32'(4 * idx);
        t.data = d;
        t.strb = w ? 4'hF : 4'h0;
        return t;
    endfunction

    function automatic void build_exp(input logic [127:0] pt, input int polls, input bit ok,
                                      input bit err_set);
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 0, 32'h0));
        exp_q.push_back(mk(1'b1, 1, pt[31:0]));
        exp_q.push_back(mk(1'b1, 2, pt[63:32]));
        exp_q.push_back(mk(1'b1, 3, pt[95:64]));
        exp_q.push_back(mk(1'b1, 4, pt[127:96]));
        exp_q.push_back(mk(1'b1, 0, 32'h1));
        if (!err_set) begin
            for (int i = 0; i < polls; i++)
                exp_q.push_back(mk(1'b0, 11, (ok && i == polls - 1) ? 32'h8000_0001 : 32'hFFFF_FFFE));
            if (ok)
                for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, 12 + k, rd_word(k)));
        end
    endfunction

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    // Offer a job, wait for acceptance; returns one cycle after the accepting edge.
    task automatic start_job(input logic [127:0] pt, input int ok_at);
        poll_ok_at = ok_at;
        poll_base  = polls_done;
        log_base   = log_q.size();
        stall_base = stall_addr_q.size();
        pt_i       = pt;
        pt_valid_i = 1'b1;
        for (int i = 0; i < 50 && !pt_ready_o; i++) tick();
        total++;
        if (pt_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: pt_ready_o=%0b required 1", pt_ready_o);
        end
        @(posedge clk_i);
        tick();
        pt_valid_i = 1'b0;
    endtask

    // Cycle 1 is the cycle after acceptance; returns cycle where ct_valid_o is seen.
    task automatic wait_ct(output int cyc);
        cyc = 1;
        while (!ct_valid_o && cyc < 200) begin
            tick();
            cyc++;
        end
        total++;
        if (ct_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL ct_valid_timeout: ct_valid_o=%0b required 1", ct_valid_o);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (pt_ready_o !== 1'b1 || ct_valid_o !== 1'b0 || ct_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: pt_ready=%0b ct_valid=%0b ct_err=%0b required 1 0 0",
                     pt_ready_o, ct_valid_o, ct_err_o);
        end
        total++;
        if (ct_o !== 128'h0) begin
            bad++;
            $display("FAIL reset_ct: ct_o=%h required 0", ct_o);
        end
        total++;
        if ({bus_valid_o, bus_write_o, bus_wstrb_o, bus_addr_o, bus_wdata_o} !== 70'h0) begin
            bad++;
            $display("FAIL reset_bus: valid=%0b write=%0b strb=%h addr=%h wdata=%h required all 0",
                     bus_valid_o, bus_write_o, bus_wstrb_o, bus_addr_o, bus_wdata_o);
        end
        rst_i = 1'b0;
        tick();
        tick();
        total++;
        if (pt_ready_o !== 1'b1 || bus_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: pt_ready=%0b bus_valid=%0b required 1 0", pt_ready_o, bus_valid_o);
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [127:0] pt;
        pt = 128'h00112233_44556677_8899aabb_ccddeeff;
        start_job(pt, 3);
        total++;
        if (bus_valid_o !== 1'b1 || bus_addr_o !== BASE) begin
            bad++;
            $display("FAIL basic_first_req: valid=%0b addr=%h required 1 %h", bus_valid_o, bus_addr_o, BASE);
        end
        wait_ct(cyc);
        total++;
        if (cyc != 14) begin
            bad++;
            $display("FAIL basic_latency: ct_valid at cycle %0d required 14", cyc);
        end
        total++;
        if (ct_o !== EXP_CT || ct_err_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_ct: ct=%h err=%0b required %h 0", ct_o, ct_err_o, EXP_CT);
        end
        build_exp(pt, 3, 1'b1, 1'b0);
        total++;
        if (log_q.size() - log_base != exp_q.size()) begin
            bad++;
            $display("FAIL basic_count: %0d txns required %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
            total++;
            if (log_q[log_base+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_txn%0d: got w=%0b a=%h d=%h s=%h required w=%0b a=%h d=%h s=%h", i,
                         log_q[log_base+i].w, log_q[log_base+i].addr, log_q[log_base+i].data,
                         log_q[log_base+i].strb, exp_q[i].w, exp_q[i].addr, exp_q[i].data, exp_q[i].strb);
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        logic [127:0] pt;
        pt = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
        stall_req = stall_done + 5;
        start_job(pt, 1);
        wait_ct(cyc);
        total++;
        if (cyc != 17) begin
            bad++;
            $display("FAIL stall_latency: ct_valid at cycle %0d required 17", cyc);
        end
        total++;
        if (stall_addr_q.size() - stall_base != 5) begin
            bad++;
            $display("FAIL stall_count: %0d stalled cycles required 5", stall_addr_q.size() - stall_base);
        end
        for (int i = stall_base; i < stall_addr_q.size(); i++) begin
            total++;
            if (stall_addr_q[i] !== BASE + 32'd12 || stall_wdata_q[i] !== 32'h76543210) begin
                bad++;
                $display("FAIL stall_hold%0d: addr=%h wdata=%h required %h 76543210", i - stall_base,
                         stall_addr_q[i], stall_wdata_q[i], BASE + 32'd12);
            end
        end
        total++;
        if (ct_o !== EXP_CT || ct_err_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_ct: ct=%h err=%0b required %h 0", ct_o, ct_err_o, EXP_CT);
        end
        build_exp(pt, 1, 1'b1, 1'b0);
        total++;
        if (log_q.size() - log_base != exp_q.size()) begin
            bad++;
            $display("FAIL stall_count_txn: %0d txns required %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
            total++;
            if (log_q[log_base+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_txn%0d: got w=%0b a=%h d=%h required w=%0b a=%h d=%h", i,
                         log_q[log_base+i].w, log_q[log_base+i].addr, log_q[log_base+i].data,
                         exp_q[i].w, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        logic [127:0] pt;
        pt = 128'h11111111_22222222_33333333_44444444;
        start_job(pt, 0);
        wait_ct(cyc);
        total++;
        if (cyc != 11) begin
            bad++;
            $display("FAIL timeout_latency: ct_valid at cycle %0d required 11", cyc);
        end
        total++;
        if (ct_err_o !== 1'b1 || ct_o !== 128'h0) begin
            bad++;
            $display("FAIL timeout_result: err=%0b ct=%h required 1 0", ct_err_o, ct_o);
        end
        build_exp(pt, PMAX, 1'b0, 1'b0);
        total++;
        if (log_q.size() - log_base != exp_q.size()) begin
            bad++;
            $display("FAIL timeout_count: %0d txns required %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
            total++;
            if (log_q[log_base+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL timeout_txn%0d: got w=%0b a=%h d=%h required w=%0b a=%h d=%h", i,
                         log_q[log_base+i].w, log_q[log_base+i].addr, log_q[log_base+i].data,
                         exp_q[i].w, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_error_set();
        int cyc;
        logic [127:0] pt;
        pt = 128'h0badf00d_cafebabe_13579bdf_2468ace0;
        err_on_set = 1'b1;
        start_job(pt, 1);
        wait_ct(cyc);
        total++;
        if (cyc != 7) begin
            bad++;
            $display("FAIL error_latency: ct_valid at cycle %0d required 7", cyc);
        end
        total++;
        if (ct_err_o !== 1'b1 || ct_o !== 128'h0) begin
            bad++;
            $display("FAIL error_result: err=%0b ct=%h required 1 0", ct_err_o, ct_o);
        end
        tick();
        tick();
        tick();
        err_on_set = 1'b0;
        build_exp(pt, 0, 1'b0, 1'b1);
        total++;
        if (log_q.size() - log_base != exp_q.size()) begin
            bad++;
            $display("FAIL error_count: %0d txns required %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
            total++;
            if (log_q[log_base+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL error_txn%0d: got w=%0b a=%h d=%h required w=%0b a=%h d=%h", i,
                         log_q[log_base+i].w, log_q[log_base+i].addr, log_q[log_base+i].data,
                         exp_q[i].w, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int held_size;
        logic [127:0] pt;
        pt = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
        ct_ready_i = 1'b0;
        start_job(pt, 2);
        wait_ct(cyc);
        held_size = log_q.size();
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ct_valid_o !== 1'b1 || ct_o !== EXP_CT || pt_ready_o !== 1'b0 || bus_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL hold_c%0d: ct_valid=%0b ct=%h pt_ready=%0b bus_valid=%0b required 1 %h 0 0",
                         i, ct_valid_o, ct_o, pt_ready_o, bus_valid_o, EXP_CT);
            end
        end
        total++;
        if (log_q.size() != held_size) begin
            bad++;
            $display("FAIL hold_traffic: %0d txns during hold required 0", log_q.size() - held_size);
        end
        // Second job offered in the same cycle the result is consumed.
        pt         = 128'h01020304_05060708_090a0b0c_0d0e0f10;
        poll_ok_at = PMAX;
        poll_base  = polls_done;
        log_base   = log_q.size();
        ct_ready_i = 1'b1;
        pt_i       = pt;
        pt_valid_i = 1'b1;
        tick();
        total++;
        if (pt_ready_o !== 1'b1 || ct_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready: pt_ready=%0b ct_valid=%0b required 1 0", pt_ready_o, ct_valid_o);
        end
        @(posedge clk_i);
        tick();
        pt_valid_i = 1'b0;
        wait_ct(cyc);
        total++;
        if (cyc != 15) begin
            bad++;
            $display("FAIL b2b_latency: ct_valid at cycle %0d required 15", cyc);
        end
        total++;
        if (ct_o !== EXP_CT || ct_err_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ct: ct=%h err=%0b required %h 0", ct_o, ct_err_o, EXP_CT);
        end
        build_exp(pt, PMAX, 1'b1, 1'b0);
        total++;
        if (log_q.size() - log_base != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count: %0d txns required %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
            total++;
            if (log_q[log_base+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_txn%0d: got w=%0b a=%h d=%h required w=%0b a=%h d=%h", i,
                         log_q[log_base+i].w, log_q[log_base+i].addr, log_q[log_base+i].data,
                         exp_q[i].w, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_poll();
        int cyc;
        logic [127:0] pt;
        pt = 128'h77777777_66666666_55555555_44444444;
        start_job(pt, 0);
        for (int i = 0; i < 30 && log_q.size() - log_base < 7; i++) tick();
        total++;
        if (bus_valid_o !== 1'b1 || bus_addr_o !== BASE + 32'd44) begin
            bad++;
            $display("FAIL rst_poll_pre: valid=%0b addr=%h required 1 %h", bus_valid_o, bus_addr_o,
                     BASE + 32'd44);
        end
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if (bus_valid_o !== 1'b0 || pt_ready_o !== 1'b1 || ct_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_poll_async: bus_valid=%0b pt_ready=%0b ct_valid=%0b required 0 1 0",
                     bus_valid_o, pt_ready_o, ct_valid_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        pt = 128'h31415926_53589793_23846264_33832795;
        start_job(pt, 2);
        wait_ct(cyc);
        total++;
        if (cyc != 13 || ct_o !== EXP_CT || ct_err_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_next_job: cycle=%0d ct=%h err=%0b required 13 %h 0", cyc, ct_o, ct_err_o,
                     EXP_CT);
        end
        build_exp(pt, 2, 1'b1, 1'b0);
        total++;
        if (log_q.size() - log_base != exp_q.size()) begin
            bad++;
            $display("FAIL rst_next_count: %0d txns required %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
            total++;
            if (log_q[log_base+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rst_next_txn%0d: got w=%0b a=%h d=%h required w=%0b a=%h d=%h", i,
                         log_q[log_base+i].w, log_q[log_base+i].addr, log_q[log_base+i].data,
                         exp_q[i].w, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_error_set();
        test_back_to_back();
        test_reset_mid_poll();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
